// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline hazard query/response bundle between the datapath and hazard_ctrl.
interface hazard_ctrl_if;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic        d_md;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_wa;
    logic [4:0]  m_wa;
    logic [4:0]  w_wa;
    logic [1:0]  e_tnew;
    logic [1:0]  m_tnew;
    logic        e_md_start;
    logic        e_md_div;
    logic        stall;
    logic        flush_e;
    logic [1:0]  fwd_d_rs;
    logic [1:0]  fwd_d_rt;
    logic [1:0]  fwd_e_rs;
    logic [1:0]  fwd_e_rt;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md, e_rs, e_rt, e_wa, m_wa, w_wa,
               e_tnew, m_tnew, e_md_start, e_md_div,
        input  stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, stall_cnt
    );
    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_md, e_rs, e_rt, e_wa, m_wa, w_wa,
               e_tnew, m_tnew, e_md_start, e_md_div,
        output stall, flush_e, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control plus HI/LO busy tracking for a 5-stage MIPS pipeline.
// Optional HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter; otherwise stall_cnt is 0.
module hazard_ctrl (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {IDLE, BUSY} md_state_e;

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        raw_rs, raw_rt;

    function automatic logic raw(input logic [4:0] src, input logic [1:0] tuse,
                                 input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                 input logic [4:0] m_wa, input logic [1:0] m_tnew);
        return (src != 5'd0) && ((src == e_wa && tuse < e_tnew) || (src == m_wa && tuse < m_tnew));
    endfunction

    // M wins over W; W results are always ready, M only once its tnew has reached 0
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_wa,
                                           input logic [1:0] m_tnew, input logic [4:0] w_wa);
        return (src == 5'd0) ? 2'd0 :
               (src == m_wa && m_tnew == 2'd0) ? 2'd1 :
               (src == w_wa) ? 2'd2 : 2'd0;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (hz.e_md_start) begin
                cnt_d   = hz.e_md_div ? 4'd10 : 4'd5;
                state_d = BUSY;
            end
        end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q <= 4'd1) ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign raw_rs     = raw(hz.d_rs, hz.d_tuse_rs, hz.e_wa, hz.e_tnew, hz.m_wa, hz.m_tnew);
    assign raw_rt     = raw(hz.d_rt, hz.d_tuse_rt, hz.e_wa, hz.e_tnew, hz.m_wa, hz.m_tnew);
    assign hz.md_busy = !reset && (hz.e_md_start || state_q == BUSY);
    assign hz.stall   = !reset && (raw_rs || raw_rt || (hz.d_md && hz.md_busy));
    assign hz.flush_e = hz.stall;
    assign hz.fwd_d_rs = fwd_sel(hz.d_rs, hz.m_wa, hz.m_tnew, hz.w_wa);
    assign hz.fwd_d_rt = fwd_sel(hz.d_rt, hz.m_wa, hz.m_tnew, hz.w_wa);
    assign hz.fwd_e_rs = fwd_sel(hz.e_rs, hz.m_wa, hz.m_tnew, hz.w_wa);
    assign hz.fwd_e_rt = fwd_sel(hz.e_rt, hz.m_wa, hz.m_tnew, hz.w_wa);

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= 32'd0;
        else if (hz.stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign hz.stall_cnt = stall_cnt_q;
`else
    assign hz.stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus, expectations from a rule-level model, queue scoreboard.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();
    hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz));

    typedef struct {
        logic        rst;
        logic [4:0]  d_rs, d_rt;
        logic [1:0]  tu_rs, tu_rt;
        logic        d_md;
        logic [4:0]  e_rs, e_rt, e_wa, m_wa, w_wa;
        logic [1:0]  e_tnew, m_tnew;
        logic        start, div;
    } stim_t;

    typedef struct {
        logic        stall, flush_e, md_busy;
        logic [1:0]  fdrs, fdrt, fers, fert;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          md_left = 0;      // busy cycles still owed after the current one
    logic [31:0] cnt_m = 32'd0;

    function automatic stim_t nop();
        stim_t s;
        s.rst = 0; s.d_rs = 0; s.d_rt = 0; s.tu_rs = 3; s.tu_rt = 3; s.d_md = 0;
        s.e_rs = 0; s.e_rt = 0; s.e_wa = 0; s.m_wa = 0; s.w_wa = 0;
        s.e_tnew = 0; s.m_tnew = 0; s.start = 0; s.div = 0;
        return s;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r, input stim_t s);
        if (r == 0) return 2'd0;
        if (r == s.m_wa && s.m_tnew == 0) return 2'd1;
        if (r == s.w_wa) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic needs_wait(input logic [4:0] r, input logic [1:0] tu, input stim_t s);
        int ready_e = (r == s.e_wa) ? int'(s.e_tnew) : 0;
        int ready_m = (r == s.m_wa) ? int'(s.m_tnew) : 0;
        return r != 0 && (int'(tu) < ready_e || int'(tu) < ready_m);
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        logic busy;
        @(posedge clk); #1;
        reset = s.rst;
        hz.d_rs = s.d_rs; hz.d_rt = s.d_rt; hz.d_tuse_rs = s.tu_rs; hz.d_tuse_rt = s.tu_rt;
        hz.d_md = s.d_md; hz.e_rs = s.e_rs; hz.e_rt = s.e_rt; hz.e_wa = s.e_wa;
        hz.m_wa = s.m_wa; hz.w_wa = s.w_wa; hz.e_tnew = s.e_tnew; hz.m_tnew = s.m_tnew;
        hz.e_md_start = s.start; hz.e_md_div = s.div;
        busy = !s.rst && (s.start || md_left > 0);
        e.md_busy = busy;
        e.stall = !s.rst && (needs_wait(s.d_rs, s.tu_rs, s) || needs_wait(s.d_rt, s.tu_rt, s) || (s.d_md && busy));
        e.flush_e = e.stall;
        e.fdrs = fwd(s.d_rs, s); e.fdrt = fwd(s.d_rt, s);
        e.fers = fwd(s.e_rs, s); e.fert = fwd(s.e_rt, s);
        e.cnt = cnt_m;
        sb.push_back(e);
        if (s.rst) begin
            md_left = 0;
            cnt_m = 0;
        end else begin
            if (md_left > 0) md_left--;
            else if (s.start) md_left = s.div ? 10 : 5;
`ifdef HAZARD_STALL_CNT_EN
            if (e.stall && cnt_m != 32'hFFFF_FFFF) cnt_m++;
`endif
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", {31'd0, hz.stall}, {31'd0, e.stall});
            chk("flush_e", {31'd0, hz.flush_e}, {31'd0, e.flush_e});
            chk("md_busy", {31'd0, hz.md_busy}, {31'd0, e.md_busy});
            chk("fwd_d_rs", {30'd0, hz.fwd_d_rs}, {30'd0, e.fdrs});
            chk("fwd_d_rt", {30'd0, hz.fwd_d_rt}, {30'd0, e.fdrt});
            chk("fwd_e_rs", {30'd0, hz.fwd_e_rs}, {30'd0, e.fers});
            chk("fwd_e_rt", {30'd0, hz.fwd_e_rt}, {30'd0, e.fert});
            chk("stall_cnt", hz.stall_cnt, e.cnt);
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1;
        hz.d_rs = 0; hz.d_rt = 0; hz.d_tuse_rs = 3; hz.d_tuse_rt = 3; hz.d_md = 0;
        hz.e_rs = 0; hz.e_rt = 0; hz.e_wa = 0; hz.m_wa = 0; hz.w_wa = 0;
        hz.e_tnew = 0; hz.m_tnew = 0; hz.e_md_start = 0; hz.e_md_div = 0;
        @(posedge clk);
        s = nop(); s.rst = 1; s.start = 1; cyc(s);
        // load-use: lw in E, then in M with tnew 1, then forwarded from M
        s = nop(); s.d_rs = 8; s.tu_rs = 1; s.e_wa = 8; s.e_tnew = 2; cyc(s);
        s = nop(); s.d_rs = 8; s.tu_rs = 1; s.m_wa = 8; s.m_tnew = 1; cyc(s);
        s = nop(); s.d_rs = 8; s.tu_rs = 1; s.m_wa = 8; s.m_tnew = 0; cyc(s);
        // mult start then dependent HI/LO instr held in D
        s = nop(); s.start = 1; cyc(s);
        for (int i = 0; i < 7; i++) begin s = nop(); s.d_md = 1; s.start = (i == 2); cyc(s); end
        // div aborted by reset in its fourth busy cycle
        s = nop(); s.start = 1; s.div = 1; cyc(s);
        for (int i = 0; i < 3; i++) begin s = nop(); s.d_md = 1; cyc(s); end
        s = nop(); s.rst = 1; s.d_md = 1; cyc(s);
        s = nop(); s.d_md = 1; cyc(s);
        // forwarding priority and register 0
        s = nop(); s.m_wa = 5; s.w_wa = 5; s.e_rs = 5; cyc(s);
        s = nop(); s.w_wa = 5; s.e_rs = 5; cyc(s);
        s = nop(); s.e_tnew = 2; s.d_rs = 0; s.tu_rs = 0; s.m_wa = 0; s.e_rt = 0; cyc(s);
        // three stall cycles from a clean counter
        s = nop(); s.rst = 1; cyc(s);
        for (int i = 0; i < 3; i++) begin s = nop(); s.d_rt = 9; s.tu_rt = 0; s.m_wa = 9; s.m_tnew = 1; cyc(s); end
        s = nop(); cyc(s);
        s = nop(); cyc(s);
        for (int i = 0; i < 400; i++) begin
            s.rst = ($urandom_range(0, 49) == 0);
            s.d_rs = 5'($urandom_range(0, 7)); s.d_rt = 5'($urandom_range(0, 7));
            s.tu_rs = 2'($urandom_range(0, 3)); s.tu_rt = 2'($urandom_range(0, 3));
            s.d_md = ($urandom_range(0, 2) == 0);
            s.e_rs = 5'($urandom_range(0, 7)); s.e_rt = 5'($urandom_range(0, 7));
            s.e_wa = 5'($urandom_range(0, 7)); s.m_wa = 5'($urandom_range(0, 7));
            s.w_wa = 5'($urandom_range(0, 7));
            s.e_tnew = 2'($urandom_range(0, 3)); s.m_tnew = 2'($urandom_range(0, 2));
            s.start = ($urandom_range(0, 5) == 0); s.div = 1'($urandom_range(0, 1));
            cyc(s);
        end
        @(negedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
